fp_divider_seq: RTL

//  Sequential IEEE-754 single-precision divider, result = a / b. Inverse of the

---
 rtl/fp_divider_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider (result = a / b).
// One restoring-division step per cycle on the mantissas, result truncated.
// Zero divisor and zero dividend short-circuit straight to DONE.
module fp_divider_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+MANT_W:0]     a,
    input  logic [EXP_W+MANT_W:0]     b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     result,
    output logic                      div_by_zero
);
    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int QW = MANT_W + 2;          // quotient / remainder width
    localparam int DW = MANT_W + 1;          // divisor width (hidden 1 + mant)
    localparam int EW = EXP_W + 2;           // signed exponent working width
    localparam int CW = $clog2(MANT_W + 2);

    localparam logic [CW-1:0]        LAST   = CW'(MANT_W + 1);
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;

    logic                     sa, sb;
    logic [EXP_W-1:0]         ea, eb;
    logic [MANT_W-1:0]        ma, mb;
    logic                     special;

    logic                     sign_r;
    logic signed [EW-1:0]     exp_diff_r;
    logic [QW-1:0]            rem_r;
    logic [DW-1:0]            div_r;
    logic [QW-1:0]            q_r;
    logic [CW-1:0]            cnt_r;

    logic                     ge;
    logic [QW-1:0]            div_ext, diff, rem_nx, q_nx;
    logic                     norm_hi;
    logic [MANT_W-1:0]        mant_n;
    logic signed [EW-1:0]     e_n;
    logic [W-1:0]             res_n;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;
    // Zero exponent means zero (denormals flushed); such operands skip BUSY
    assign special = (eb == '0) || (ea == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = special ? DONE : BUSY;
            end
            BUSY: if (cnt_r == LAST) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One restoring step: remainder always stays below 2*divisor, so the
    // shifted-out top bit is always zero
    always_comb begin
        div_ext = {1'b0, div_r};
        ge      = (rem_r >= div_ext);
        diff    = rem_r - div_ext;
        rem_nx  = ge ? {diff[QW-2:0], 1'b0} : {rem_r[QW-2:0], 1'b0};
        q_nx    = {q_r[QW-2:0], ge};
    end

    // Normalize the final quotient (in [0.5,2)) and range-check the exponent
    always_comb begin
        norm_hi = q_nx[QW-1];
        mant_n  = norm_hi ? q_nx[MANT_W:1] : q_nx[MANT_W-1:0];
        e_n     = exp_diff_r + BIAS_S;
        if (!norm_hi) e_n = e_n - ONE_S;
        if (e_n >= EMAX)
            res_n = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        else if (e_n <= 0)
            res_n = {sign_r, {(EXP_W+MANT_W){1'b0}}};
        else
            res_n = {sign_r, e_n[EXP_W-1:0], mant_n};
    end

    // Datapath: latch operands on accept, iterate in BUSY, register result
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r      <= 1'b0;
            exp_diff_r  <= '0;
            rem_r       <= '0;
            div_r       <= '0;
            q_r         <= '0;
            cnt_r       <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_r <= sa ^ sb;
                    if (eb == '0) begin
                        result      <= {sa ^ sb, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        div_by_zero <= 1'b1;
                    end else if (ea == '0) begin
                        result      <= {sa ^ sb, {(EXP_W+MANT_W){1'b0}}};
                        div_by_zero <= 1'b0;
                    end else begin
                        exp_diff_r <= $signed({2'b00, ea}) - $signed({2'b00, eb});
                        rem_r      <= {1'b0, 1'b1, ma};
                        div_r      <= {1'b1, mb};
                        q_r        <= '0;
                        cnt_r      <= '0;
                    end
                end
                BUSY: begin
                    rem_r <= rem_nx;
                    q_r   <= q_nx;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        result      <= res_n;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
